// File: rtl/rv_pkg.sv
// Shared definitions for the writeback stage: load funct3 encodings and
// the writeback FSM state type.
package rv_pkg;

  localparam logic [2:0] LB  = 3'd0;
  localparam logic [2:0] LH  = 3'd1;
  localparam logic [2:0] LW  = 3'd2;
  localparam logic [2:0] LD  = 3'd3;
  localparam logic [2:0] LBU = 3'd4;
  localparam logic [2:0] LHU = 3'd5;
  localparam logic [2:0] LWU = 3'd6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ECALL_REQ = 2'd1,
    ECALL_WB  = 2'd2
  } wb_state_t;

endpackage

// File: rtl/writeback_stage_if.sv
// Bundle between memory stage / ecall handler (master) and the writeback
// stage (slave), including the register-file and retirement outputs.
interface writeback_stage_if #(
  parameter int XLEN  = 64,
  parameter int PC_W  = 32,
  parameter int CNT_W = 64
);
  logic             in_valid;
  logic [XLEN-1:0]  in_data;
  logic [4:0]       in_rd;
  logic             in_ld_or_alu;
  logic [2:0]       in_ld_funct3;
  logic [2:0]       in_addr_lo;
  logic [PC_W-1:0]  in_pc;
  logic             in_is_ecall;
  logic [XLEN-1:0]  ecall_ret;
  logic             ecall_ack;
  logic             wb_stall;
  logic             rf_wr_en;
  logic [4:0]       rf_wr_addr;
  logic [XLEN-1:0]  rf_wr_data;
  logic             sb_clear_en;
  logic [4:0]       sb_clear_idx;
  logic             ecall_req;
  logic [PC_W-1:0]  ecall_pc;
  logic [PC_W-1:0]  retired_pc;
  logic [CNT_W-1:0] retired_cnt;

  modport master (
    output in_valid, in_data, in_rd, in_ld_or_alu, in_ld_funct3, in_addr_lo,
           in_pc, in_is_ecall, ecall_ret, ecall_ack,
    input  wb_stall, rf_wr_en, rf_wr_addr, rf_wr_data, sb_clear_en,
           sb_clear_idx, ecall_req, ecall_pc, retired_pc, retired_cnt
  );

  modport slave (
    input  in_valid, in_data, in_rd, in_ld_or_alu, in_ld_funct3, in_addr_lo,
           in_pc, in_is_ecall, ecall_ret, ecall_ack,
    output wb_stall, rf_wr_en, rf_wr_addr, rf_wr_data, sb_clear_en,
           sb_clear_idx, ecall_req, ecall_pc, retired_pc, retired_cnt
  );
endinterface

// File: rtl/load_extend.sv
// Combinational load alignment: shift the addressed byte lane down, then
// sign- or zero-extend per funct3. Unused funct3 behaves as LD.
module load_extend
  import rv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [2:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] lane;

  // Misaligned offsets are deliberately not trapped; the shift is applied as-is.
  assign lane = data_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o = lane;
    case (funct3_i)
      LB:      data_o = {{(XLEN-8){lane[7]}},   lane[7:0]};
      LH:      data_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
      LW:      data_o = {{(XLEN-32){lane[31]}}, lane[31:0]};
      LBU:     data_o = {{(XLEN-8){1'b0}},      lane[7:0]};
      LHU:     data_o = {{(XLEN-16){1'b0}},     lane[15:0]};
      LWU:     data_o = {{(XLEN-32){1'b0}},     lane[31:0]};
      default: data_o = lane;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: registered register-file writes, scoreboard clears,
// retirement tracking and a blocking ecall handshake that stalls upstream.
module writeback_stage
  import rv_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter int PC_W          = 32,
  parameter int CNT_W         = 64,
  parameter int ECALL_RET_REG = 10
) (
  input  logic              clk,
  input  logic              rst,
  writeback_stage_if.slave  bus
);

  wb_state_t        state_q, state_d;
  logic             rf_wr_en_q, rf_wr_en_d;
  logic [4:0]       rf_wr_addr_q, rf_wr_addr_d;
  logic [XLEN-1:0]  rf_wr_data_q, rf_wr_data_d;
  logic [PC_W-1:0]  ecall_pc_q, ecall_pc_d;
  logic [PC_W-1:0]  retired_pc_q, retired_pc_d;
  logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
  logic [XLEN-1:0]  ext_data;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .data_i    (bus.in_data),
    .addr_lo_i (bus.in_addr_lo),
    .funct3_i  (bus.in_ld_funct3),
    .data_o    (ext_data)
  );

  always_comb begin
    state_d       = state_q;
    rf_wr_en_d    = 1'b0;
    rf_wr_addr_d  = '0;
    rf_wr_data_d  = '0;
    ecall_pc_d    = ecall_pc_q;
    retired_pc_d  = retired_pc_q;
    retired_cnt_d = retired_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_is_ecall) begin
          state_d    = ECALL_REQ;
          ecall_pc_d = bus.in_pc;
        end else if (bus.in_valid) begin
          rf_wr_en_d    = (bus.in_rd != 5'd0);
          rf_wr_addr_d  = bus.in_rd;
          rf_wr_data_d  = bus.in_ld_or_alu ? ext_data : bus.in_data;
          retired_pc_d  = bus.in_pc;
          retired_cnt_d = retired_cnt_q + CNT_W'(1);
        end
      end
      ECALL_REQ: begin
        // The write flops double as the ecall_ret latch, so the a0 write
        // appears exactly in the ECALL_WB cycle.
        if (bus.ecall_ack) begin
          state_d       = ECALL_WB;
          rf_wr_en_d    = 1'b1;
          rf_wr_addr_d  = 5'(ECALL_RET_REG);
          rf_wr_data_d  = bus.ecall_ret;
          retired_pc_d  = ecall_pc_q;
          retired_cnt_d = retired_cnt_q + CNT_W'(1);
        end
      end
      ECALL_WB: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      rf_wr_en_q    <= 1'b0;
      rf_wr_addr_q  <= '0;
      rf_wr_data_q  <= '0;
      ecall_pc_q    <= '0;
      retired_pc_q  <= '0;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      rf_wr_en_q    <= rf_wr_en_d;
      rf_wr_addr_q  <= rf_wr_addr_d;
      rf_wr_data_q  <= rf_wr_data_d;
      ecall_pc_q    <= ecall_pc_d;
      retired_pc_q  <= retired_pc_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign bus.wb_stall     = (state_q != IDLE);
  assign bus.ecall_req    = (state_q == ECALL_REQ);
  assign bus.ecall_pc     = ecall_pc_q;
  assign bus.rf_wr_en     = rf_wr_en_q;
  assign bus.rf_wr_addr   = rf_wr_addr_q;
  assign bus.rf_wr_data   = rf_wr_data_q;
  assign bus.sb_clear_en  = rf_wr_en_q;
  assign bus.sb_clear_idx = rf_wr_addr_q;
  assign bus.retired_pc   = retired_pc_q;
  assign bus.retired_cnt  = retired_cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU/load writes, extension cases,
// x0 suppression, ecall handshake with stall, and async reset mid-ecall.
module tb_writeback_stage;
  import rv_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  writeback_stage_if #(.XLEN(64), .PC_W(32), .CNT_W(64)) bus ();

  writeback_stage #(.XLEN(64), .PC_W(32), .CNT_W(64), .ECALL_RET_REG(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [4:0] rd,
                       input logic ld, input logic [2:0] f3, input logic [2:0] lo,
                       input logic [31:0] pc, input logic ec);
    bus.in_valid     = v;
    bus.in_data      = d;
    bus.in_rd        = rd;
    bus.in_ld_or_alu = ld;
    bus.in_ld_funct3 = f3;
    bus.in_addr_lo   = lo;
    bus.in_pc        = pc;
    bus.in_is_ecall  = ec;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [4:0] a,
                        input logic [63:0] d, input logic [63:0] cnt);
    chk({tag, "_en"},   64'(bus.rf_wr_en), 64'(en));
    chk({tag, "_sb"},   64'(bus.sb_clear_en), 64'(en));
    if (en) begin
      chk({tag, "_addr"}, 64'(bus.rf_wr_addr), 64'(a));
      chk({tag, "_sbidx"}, 64'(bus.sb_clear_idx), 64'(a));
      chk({tag, "_data"}, bus.rf_wr_data, d);
    end
    chk({tag, "_cnt"},  bus.retired_cnt, cnt);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.ecall_ret = '0;
    bus.ecall_ack = 1'b0;
    drive(1'b0, 64'h0, 5'd0, 1'b0, LD, 3'd0, 32'h0, 1'b0);
    step();
    step();
    chk("rst_wr_en",  64'(bus.rf_wr_en), 64'd0);
    chk("rst_stall",  64'(bus.wb_stall), 64'd0);
    chk("rst_req",    64'(bus.ecall_req), 64'd0);
    chk("rst_cnt",    bus.retired_cnt, 64'd0);
    chk("rst_rpc",    64'(bus.retired_pc), 64'd0);
    rst = 1'b1;
    step();

    // ALU write to x5
    drive(1'b1, 64'h1234, 5'd5, 1'b0, LB, 3'd0, 32'h10, 1'b0);
    step();
    chk_wr("alu", 1'b1, 5'd5, 64'h1234, 64'd1);
    chk("alu_rpc", 64'(bus.retired_pc), 64'h10);

    // Idle cycle: no write, no count change, stray ack ignored
    drive(1'b0, 64'h0, 5'd9, 1'b0, LB, 3'd0, 32'h14, 1'b0);
    bus.ecall_ack = 1'b1;
    step();
    bus.ecall_ack = 1'b0;
    chk_wr("idle", 1'b0, 5'd0, 64'h0, 64'd1);
    chk("idle_req", 64'(bus.ecall_req), 64'd0);

    drive(1'b1, 64'h00000000_0080FF00, 5'd6, 1'b1, LB, 3'd1, 32'h18, 1'b0);
    step();
    chk_wr("lb", 1'b1, 5'd6, 64'hFFFFFFFF_FFFFFFFF, 64'd2);
    drive(1'b1, 64'h00000000_0080FF00, 5'd6, 1'b1, LBU, 3'd1, 32'h1C, 1'b0);
    step();
    chk_wr("lbu", 1'b1, 5'd6, 64'h0000_0000_0000_00FF, 64'd3);
    drive(1'b1, 64'h80000000_00000000, 5'd7, 1'b1, LW, 3'd4, 32'h20, 1'b0);
    step();
    chk_wr("lw", 1'b1, 5'd7, 64'hFFFFFFFF_80000000, 64'd4);
    drive(1'b1, 64'h80000000_00000000, 5'd7, 1'b1, LWU, 3'd4, 32'h24, 1'b0);
    step();
    chk_wr("lwu", 1'b1, 5'd7, 64'h00000000_80000000, 64'd5);
    drive(1'b1, 64'h0000_0000_9ABC_0000, 5'd8, 1'b1, LH, 3'd2, 32'h28, 1'b0);
    step();
    chk_wr("lh", 1'b1, 5'd8, 64'hFFFFFFFF_FFFF9ABC, 64'd6);
    drive(1'b1, 64'h0000_0000_9ABC_0000, 5'd8, 1'b1, LHU, 3'd2, 32'h2C, 1'b0);
    step();
    chk_wr("lhu", 1'b1, 5'd8, 64'h00000000_00009ABC, 64'd7);
    // Misaligned LD just shifts
    drive(1'b1, 64'h1122334455667788, 5'd9, 1'b1, LD, 3'd2, 32'h30, 1'b0);
    step();
    chk_wr("ld_mis", 1'b1, 5'd9, 64'h0000112233445566, 64'd8);
    drive(1'b1, 64'h1122334455667788, 5'd9, 1'b1, 3'b111, 3'd0, 32'h34, 1'b0);
    step();
    chk_wr("f3_111", 1'b1, 5'd9, 64'h1122334455667788, 64'd9);

    // x0 retires without writing
    drive(1'b1, 64'hDEAD, 5'd0, 1'b0, LB, 3'd0, 32'h38, 1'b0);
    step();
    chk_wr("x0", 1'b0, 5'd0, 64'h0, 64'd10);
    chk("x0_rpc", 64'(bus.retired_pc), 64'h38);

    // ecall at 0x100; a different instruction is held during the stall
    drive(1'b1, 64'h0, 5'd3, 1'b0, LB, 3'd0, 32'h100, 1'b1);
    step();
    drive(1'b1, 64'h77, 5'd7, 1'b0, LB, 3'd0, 32'h104, 1'b0);
    chk("ec_req1",   64'(bus.ecall_req), 64'd1);
    chk("ec_stall1", 64'(bus.wb_stall), 64'd1);
    chk("ec_pc",     64'(bus.ecall_pc), 64'h100);
    chk_wr("ec_nowr", 1'b0, 5'd0, 64'h0, 64'd10);
    step();
    chk("ec_req2",   64'(bus.ecall_req), 64'd1);
    chk("ec_stall2", 64'(bus.wb_stall), 64'd1);
    chk_wr("ec_nowr2", 1'b0, 5'd0, 64'h0, 64'd10);
    step();
    chk("ec_req3",   64'(bus.ecall_req), 64'd1);
    chk("ec_stall3", 64'(bus.wb_stall), 64'd1);
    bus.ecall_ret = 64'd42;
    bus.ecall_ack = 1'b1;
    step();
    bus.ecall_ack = 1'b0;
    bus.ecall_ret = 64'd99;
    chk_wr("ec_wb", 1'b1, 5'd10, 64'd42, 64'd11);
    chk("ec_wb_rpc",   64'(bus.retired_pc), 64'h100);
    chk("ec_wb_req",   64'(bus.ecall_req), 64'd0);
    chk("ec_wb_stall", 64'(bus.wb_stall), 64'd1);
    step();
    chk("ec_idle_stall", 64'(bus.wb_stall), 64'd0);
    chk_wr("ec_idle", 1'b0, 5'd0, 64'h0, 64'd11);
    step();
    chk_wr("post_ec", 1'b1, 5'd7, 64'h77, 64'd12);
    chk("post_ec_rpc", 64'(bus.retired_pc), 64'h104);

    // Ack in the first ECALL_REQ cycle is accepted
    drive(1'b1, 64'h0, 5'd0, 1'b0, LB, 3'd0, 32'h200, 1'b1);
    step();
    drive(1'b0, 64'h0, 5'd0, 1'b0, LB, 3'd0, 32'h0, 1'b0);
    chk("fast_req", 64'(bus.ecall_req), 64'd1);
    bus.ecall_ret = 64'h5;
    bus.ecall_ack = 1'b1;
    step();
    bus.ecall_ack = 1'b0;
    chk_wr("fast_wb", 1'b1, 5'd10, 64'h5, 64'd13);
    chk("fast_rpc", 64'(bus.retired_pc), 64'h200);
    step();

    // Async reset while in ECALL_REQ
    drive(1'b1, 64'h0, 5'd0, 1'b0, LB, 3'd0, 32'h300, 1'b1);
    step();
    drive(1'b0, 64'h0, 5'd0, 1'b0, LB, 3'd0, 32'h0, 1'b0);
    chk("ar_req_pre", 64'(bus.ecall_req), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("ar_req",   64'(bus.ecall_req), 64'd0);
    chk("ar_stall", 64'(bus.wb_stall), 64'd0);
    chk("ar_cnt",   bus.retired_cnt, 64'd0);
    chk("ar_wr",    64'(bus.rf_wr_en), 64'd0);
    bus.ecall_ret = 64'h1;
    bus.ecall_ack = 1'b1;
    step();
    bus.ecall_ack = 1'b0;
    chk("ar_hold_wr", 64'(bus.rf_wr_en), 64'd0);
    rst = 1'b1;
    step();
    chk("ar_rel_wr", 64'(bus.rf_wr_en), 64'd0);
    drive(1'b1, 64'hABCD, 5'd12, 1'b0, LB, 3'd0, 32'h400, 1'b0);
    step();
    drive(1'b0, 64'h0, 5'd0, 1'b0, LB, 3'd0, 32'h0, 1'b0);
    chk_wr("ar_alu", 1'b1, 5'd12, 64'hABCD, 64'd1);
    chk("ar_alu_rpc", 64'(bus.retired_pc), 64'h400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Final pipeline stage, directly downstream of the memory stage. Consumes the memory stage's result, destination register, load/ALU select, PC and ecall flag. Produces registered register-file writes, with load data aligned and extended from the byte lane. Runs a blocking ecall handshake that stalls the pipeline until the handler returns a value for a0 (x10). Also drives scoreboard-clear and retirement counters.

Parameters:
XLEN, 64, datapath width
PC_W, 32, program counter width
CNT_W, 64, width of retired-instruction counter
ECALL_RET_REG, 10, architectural register written with the ecall return value

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous and active-low (asserted at 0)
in_valid  input  1  memory stage presents an instruction this cycle
in_data  input  XLEN  ALU result or raw 64-bit cache line word
in_rd  input  5  destination register (0 = no write)
in_ld_or_alu  input  1  1 = load data, 0 = ALU result
in_ld_funct3  input  3  load funct3 (LB/LH/LW/LD/LBU/LHU/LWU)
in_addr_lo  input  3  low address bits of the load
in_pc  input  PC_W  instruction PC
in_is_ecall  input  1  instruction is ecall
ecall_ret  input  XLEN  handler return value
ecall_ack  input  1  handler done; ecall_ret valid this cycle
wb_stall  output  1  upstream must hold its outputs stable
rf_wr_en  output  1  register-file write enable
rf_wr_addr  output  5  register-file write index
rf_wr_data  output  XLEN  register-file write data
sb_clear_en  output  1  clear scoreboard busy bit
sb_clear_idx  output  5  scoreboard index to clear
ecall_req  output  1  request to ecall handler
ecall_pc  output  PC_W  PC of the pending ecall
retired_pc  output  PC_W  PC of last retired instruction
retired_cnt  output  CNT_W  count of retired instructions

Behaviour:
- Reset: every output is 0. The FSM goes to IDLE.
- FSM states: IDLE, ECALL_REQ, ECALL_WB.
- IDLE, in_valid=1 and in_is_ecall=0:
  - Next cycle: rf_wr_en = (in_rd != 0), rf_wr_addr = in_rd, rf_wr_data = extended value.
  - sb_clear_en and sb_clear_idx mirror rf_wr_en and rf_wr_addr.
  - retired_cnt increments by 1; retired_pc = in_pc.
  - One-cycle latency; all of these are pulses of one cycle.
- Load extension (in_ld_or_alu=1):
  - Byte lane = in_data >> (8*in_addr_lo).
  - LB/LH/LW sign-extend 8/16/32 bits. LBU/LHU/LWU zero-extend. LD passes 64 bits through.
  - Misaligned addresses are not checked; the lane shift is applied as-is.
  - Unused funct3 codes (3'b111) are treated as LD.
- ALU results (in_ld_or_alu=0) pass through unchanged.
- x0: never written (rf_wr_en=0, sb_clear_en=0), but the instruction still retires.
- IDLE, in_valid=1 and in_is_ecall=1:
  - Next cycle: state = ECALL_REQ, ecall_req=1, ecall_pc=in_pc, wb_stall=1.
  - No register write in this cycle.
- ECALL_REQ:
  - ecall_req and wb_stall stay high until ecall_ack=1.
  - On the ack cycle, latch ecall_ret. Next cycle: state = ECALL_WB, ecall_req=0.
  - An ack arriving in the same cycle ecall_req first rises is accepted.
- ECALL_WB (one cycle):
  - rf_wr_en=1, rf_wr_addr=ECALL_RET_REG, rf_wr_data=latched value.
  - sb_clear_en=1 on ECALL_RET_REG.
  - retired_cnt increments; retired_pc = ecall_pc.
  - wb_stall stays high this cycle and drops next cycle (state = IDLE).
- Stall contract: while wb_stall=1, in_* inputs are ignored. Upstream holds them; they are sampled again in the first IDLE cycle.
- ecall_ack outside ECALL_REQ is ignored.
- in_valid=0 in IDLE produces no writes and no count change.
- retired_cnt wraps modulo 2^CNT_W.
- Async reset mid-ecall: immediately clears ecall_req, wb_stall and state; no write occurs.

Decomposition:
- Package rv_pkg holds the load funct3 localparams (LB=0, LH=1, LW=2, LD=3, LBU=4, LHU=5, LWU=6) and the FSM enum wb_state_t.
- One sub-module, load_extend: combinational lane select plus sign/zero extension, reused by later bypass logic.

Test Plan:
- ALU write: in_valid, rd=5, in_data=0x1234, ld_or_alu=0 -> next cycle rf_wr_en=1, addr 5, data 0x1234, sb_clear_idx=5, retired_cnt=1.
- LB sign-extension: in_data=0x00000000_0080FF00, addr_lo=1, funct3=LB -> rf_wr_data=0xFFFFFFFF_FFFFFFFF. Same stimulus with LBU -> 0xFF.
- LW at addr_lo=4, in_data=0x80000000_00000000 -> 0xFFFFFFFF_80000000. LWU -> 0x80000000.
- rd=0 ALU op -> rf_wr_en=0, sb_clear_en=0, retired_cnt increments.
- ecall at pc=0x100, ack after 3 cycles with ecall_ret=42:
  - ecall_req high for 3 cycles and wb_stall high throughout.
  - Then a write of x10=42, retired_pc=0x100.
  - wb_stall low on the following cycle.
- Reset (rst=0) asserted during ECALL_REQ -> outputs 0 immediately. After release, a new ALU op writes normally.
